// File: rtl/pid_mc_if.sv
// Port bundle for pid_mc_core: per-channel configuration, samples and strobed outputs.
// slew_i is present only when PID_SLEW_LIMIT_EN is defined.
interface pid_mc_if #(
  parameter int NCH   = 2,
  parameter int IN_W  = 16,
  parameter int OUT_W = 14,
  parameter int K_W   = 16,
  parameter int DEC_W = 14
);
  logic [NCH-1:0]       enable_i;
  logic [NCH*IN_W-1:0]  dat_i;
  logic [NCH*IN_W-1:0]  sp_i;
  logic [NCH*K_W-1:0]   kp_i;
  logic [NCH*K_W-1:0]   ki_i;
  logic [NCH*K_W-1:0]   kd_i;
  logic [NCH*4-1:0]     alpha_i;
  logic [NCH*5-1:0]     satwidth_i;
  logic [DEC_W-1:0]     decimate_i;
  logic [NCH-1:0]       int_hold_i;
`ifdef PID_SLEW_LIMIT_EN
  logic [NCH*OUT_W-1:0] slew_i;
`endif
  logic [NCH*OUT_W-1:0] pid_out;
  logic [NCH-1:0]       out_valid_o;

  // out_valid_o[c] is a one-cycle valid strobe with no ready: the consumer latches
  // pid_out[c] on the strobe; pid_out[c] holds its value until the next strobe.
  modport master (
    output enable_i, dat_i, sp_i, kp_i, ki_i, kd_i, alpha_i, satwidth_i,
    output decimate_i, int_hold_i,
`ifdef PID_SLEW_LIMIT_EN
    output slew_i,
`endif
    input  pid_out, out_valid_o
  );

  modport slave (
    input  enable_i, dat_i, sp_i, kp_i, ki_i, kd_i, alpha_i, satwidth_i,
    input  decimate_i, int_hold_i,
`ifdef PID_SLEW_LIMIT_EN
    input  slew_i,
`endif
    output pid_out, out_valid_o
  );
endinterface

// File: rtl/pid_mc_core.sv
// NCH-channel PID controller: shared decimation tick, EMA-filtered derivative, clamped
// anti-windup integrator. Define PID_SLEW_LIMIT_EN for a slew-limited output stage.
module pid_mc_core #(
  parameter int NCH   = 2,
  parameter int IN_W  = 16,
  parameter int OUT_W = 14,
  parameter int K_W   = 16,
  parameter int ACC_W = 32,
  parameter int DEC_W = 14
) (
  input  logic     clk,
  input  logic     rst,
  pid_mc_if.slave  bus
);
  localparam int E_W  = IN_W + 1;
  localparam int DY_W = IN_W + 2;
  localparam int PP_W = K_W + E_W;
  localparam int DP_W = K_W + DY_W;
  localparam int IP_W = K_W + ACC_W;
  localparam int T_W  = OUT_W + 8;
  localparam logic [OUT_W-1:0] MID  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] FULL = '1;

  logic [DEC_W-1:0] dec_r;
  logic [DEC_W-1:0] cnt;
  logic             any_en;
  logic             tick;

  assign any_en = |bus.enable_i;
  assign tick   = any_en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_r <= DEC_W'(1);
      cnt   <= '0;
    end else begin
      dec_r <= (bus.decimate_i == '0) ? DEC_W'(1) : bus.decimate_i;
      if (!any_en)                      cnt <= '0;
      else if (cnt >= dec_r - DEC_W'(1)) cnt <= '0;
      else                              cnt <= cnt + DEC_W'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : gen_ch
    logic signed [IN_W-1:0]  dat_c;
    logic signed [IN_W-1:0]  sp_r;
    logic signed [K_W-1:0]   kp_r, ki_r, kd_r;
    logic [3:0]              alpha_r;
    logic [4:0]              sw_in, sw_r, sw_q;
    logic                    en;
    logic signed [E_W-1:0]   err, y, y_next, err_q;
    logic signed [DY_W-1:0]  dy, dy_q;
    logic signed [ACC_W-1:0] sum, sum_wr;
    logic signed [ACC_W:0]   sum_ext, lim, sum_cl;
    logic                    hold_wr;
    logic                    v1, v2;
    logic signed [PP_W-1:0]  p_prod;
    logic signed [DP_W-1:0]  d_prod;
    logic signed [IP_W-1:0]  i_prod;
    logic signed [T_W-1:0]   tot;
    logic [OUT_W-1:0]        res;
    logic [OUT_W-1:0]        out_r;
    logic                    vld;

    assign en    = bus.enable_i[g];
    assign dat_c = bus.dat_i[g*IN_W +: IN_W];
    assign sw_in = bus.satwidth_i[g*5 +: 5];

    always_ff @(posedge clk) begin
      if (rst) begin
        sp_r    <= '0;
        kp_r    <= '0;
        ki_r    <= '0;
        kd_r    <= '0;
        alpha_r <= '0;
        sw_r    <= 5'(ACC_W-1);
      end else begin
        sp_r    <= bus.sp_i[g*IN_W +: IN_W];
        kp_r    <= bus.kp_i[g*K_W +: K_W];
        ki_r    <= bus.ki_i[g*K_W +: K_W];
        kd_r    <= bus.kd_i[g*K_W +: K_W];
        alpha_r <= bus.alpha_i[g*4 +: 4];
        sw_r    <= (sw_in >= 5'd15 && int'(sw_in) <= ACC_W-1) ? sw_in : 5'(ACC_W-1);
      end
    end

    // S1: error, EMA and integrator update; anti-windup looks at the output currently shown.
    always_comb begin
      err     = E_W'(dat_c) - E_W'(sp_r);
      dy      = DY_W'(err) - DY_W'(y);
      y_next  = y + E_W'(dy >>> alpha_r);
      sum_ext = (ACC_W+1)'(sum) + (ACC_W+1)'(err);
      lim     = ((ACC_W+1)'(1) <<< sw_r) - (ACC_W+1)'(1);
      if (sum_ext > lim)       sum_cl = lim;
      else if (sum_ext < -lim) sum_cl = -lim;
      else                     sum_cl = sum_ext;
      hold_wr = bus.int_hold_i[g]
             || (out_r == FULL && sum_cl > (ACC_W+1)'(sum))
             || (out_r == '0   && sum_cl < (ACC_W+1)'(sum));
      sum_wr  = hold_wr ? sum : sum_cl[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst || !en) begin
        sum   <= '0;
        y     <= '0;
        err_q <= '0;
        dy_q  <= '0;
        v1    <= 1'b0;
      end else begin
        v1 <= tick;
        if (tick) begin
          sum   <= sum_wr;
          y     <= y_next;
          err_q <= err;
          dy_q  <= dy;
        end
      end
    end

    // S2: full-width products; sum still holds the value written at the tick.
    always_ff @(posedge clk) begin
      if (rst || !en) begin
        v2     <= 1'b0;
        p_prod <= '0;
        d_prod <= '0;
        i_prod <= '0;
        sw_q   <= 5'(ACC_W-1);
      end else begin
        v2 <= v1;
        if (v1) begin
          p_prod <= PP_W'(kp_r) * PP_W'(err_q);
          d_prod <= DP_W'(kd_r) * DP_W'(dy_q);
          i_prod <= IP_W'(ki_r) * IP_W'(sum);
          sw_q   <= sw_r;
        end
      end
    end

    // S3: each term is bounded well inside T_W, so truncation before the add cannot wrap.
    always_comb begin
      tot = T_W'(p_prod >>> 15) + T_W'(d_prod >>> 15) + T_W'(i_prod >>> sw_q)
          + $signed(T_W'(MID));
      if (tot < 0)                            res = '0;
      else if (tot > $signed(T_W'(FULL)))     res = FULL;
      else                                    res = tot[OUT_W-1:0];
    end

`ifdef PID_SLEW_LIMIT_EN
    logic [OUT_W-1:0]      slew;
    logic [OUT_W-1:0]      res_q;
    logic [OUT_W-1:0]      lim_out;
    logic signed [OUT_W:0] step_d;
    logic                  v3;

    assign slew = bus.slew_i[g*OUT_W +: OUT_W];

    always_comb begin
      step_d  = $signed({1'b0, res_q}) - $signed({1'b0, out_r});
      lim_out = res_q;
      if (slew != '0) begin
        if (step_d > $signed({1'b0, slew}))       lim_out = out_r + slew;
        else if (step_d < -$signed({1'b0, slew})) lim_out = out_r - slew;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || !en) begin
        res_q <= MID;
        v3    <= 1'b0;
        out_r <= MID;
        vld   <= 1'b0;
      end else begin
        v3  <= v2;
        vld <= v3;
        if (v2) res_q <= res;
        if (v3) out_r <= lim_out;
      end
    end
`else
    always_ff @(posedge clk) begin
      if (rst || !en) begin
        out_r <= MID;
        vld   <= 1'b0;
      end else begin
        vld <= v2;
        if (v2) out_r <= res;
      end
    end
`endif

    assign bus.pid_out[g*OUT_W +: OUT_W] = out_r;
    assign bus.out_valid_o[g]            = vld;
  end
endmodule
